// File: rtl/alu_op_scheduler_pkg.sv
// Shared types and widths for the ALU operation scheduler slice.
package alu_pkg;

  localparam int unsigned RESULT_W = 8;
  localparam int unsigned OPND_W   = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/alu_op_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the pointer side.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU core between two requesters: arbitrate, latch operands,
// hold alu_start for the settle window, capture and return the result.
module alu_op_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  input  logic [OPND_W-1:0]   a0,
  input  logic [OPND_W-1:0]   b0,
  input  logic [1:0]          op0,
  input  logic [OPND_W-1:0]   a1,
  input  logic [OPND_W-1:0]   b1,
  input  logic [1:0]          op1,
  output logic [1:0]          grant,
  output logic [1:0]          done,
  output logic                err,
  output logic [RESULT_W-1:0] result,
  output logic [OPND_W-1:0]   alu_a,
  output logic [OPND_W-1:0]   alu_b,
  output logic [1:0]          alu_op,
  output logic                alu_start,
  input  logic [RESULT_W-1:0] alu_result,
  output logic                busy
);

  sched_state_t        state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                ptr_q, ptr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [OPND_W-1:0]   a_q, a_d, b_q, b_d;
  alu_op_t             op_q, op_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic [1:0]          gnt_w;

  rr_arbiter_2 u_arb (
    .req (req),
    .ptr (ptr_q),
    .en  (state_q == S_IDLE),
    .gnt (gnt_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      ptr_q    <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_w != 2'b00) begin
          grant_d = gnt_w;
          a_d     = gnt_w[1] ? a1 : a0;
          b_d     = gnt_w[1] ? b1 : b0;
          op_d    = alu_op_t'(gnt_w[1] ? op1 : op0);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 4'(SETTLE_CYCLES);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Capture on the last settle cycle so DONE presents a stable result.
        if (cnt_q <= 4'd1) begin
          result_d = (op_q == OP_RSV) ? '0 : alu_result;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = grant_q[0];
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign grant     = grant_q;
  assign done      = (state_q == S_DONE) ? grant_q : 2'b00;
  assign err       = (state_q == S_DONE) && (op_q == OP_RSV);
  assign result    = result_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign alu_start = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler; the bench itself plays the ALU core.
module tb_alu_op_scheduler;

  localparam int unsigned SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;
  logic [1:0] grant, done;
  logic       err;
  logic [7:0] result;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic       alu_start;
  logic [7:0] alu_result;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_op_scheduler #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .a0         (a0),
    .b0         (b0),
    .op0        (op0),
    .a1         (a1),
    .b1         (b1),
    .op1        (op1),
    .grant      (grant),
    .done       (done),
    .err        (err),
    .result     (result),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ALU core stand-in; the reserved opcode returns garbage the scheduler must mask.
  always_comb begin
    logic [4:0] sum;
    logic [3:0] dif;
    sum = {1'b0, alu_a} + {1'b0, alu_b};
    dif = alu_a - alu_b;
    case (alu_op)
      2'b00:   alu_result = {3'b000, sum};
      2'b01:   alu_result = {4'h0, dif};
      2'b10:   alu_result = alu_a * alu_b;
      default: alu_result = 8'hA5;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int idx, input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done[idx] && cyc < 40);
    check(tag, 32'(done[idx]), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    int gap;
    logic [1:0] exp_g;
    rst_n = 1'b1;
    req = '0; a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_start", 32'(alu_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_result", 32'(result), 0);
    check("rst_opnd", 32'({alu_a, alu_b, alu_op}), 0);
    rst_n = 1'b1;

    // Single add 9+8
    @(negedge clk);
    req = 2'b01; a0 = 4'd9; b0 = 4'd8; op0 = 2'b00;
    @(negedge clk);
    check("add_grant", 32'(grant), 32'h1);
    check("add_busy", 32'(busy), 1);
    check("add_start", 32'(alu_start), 1);
    check("add_alu_a", 32'(alu_a), 9);
    wait_done(0, "add_done", cyc);
    check("add_latency", 32'(cyc), SETTLE + 1);
    check("add_result", 32'(result), 17);
    check("add_err", 32'(err), 0);
    check("add_start_off", 32'(alu_start), 0);
    req = 2'b00;
    @(negedge clk);
    check("add_pulse", 32'(done), 0);
    check("add_idle", 32'({grant, busy}), 0);
    check("add_hold", 32'(result), 17);

    // Contention from reset: r0 mul 15*15, r1 sub 3-5
    do_reset();
    a0 = 4'd15; b0 = 4'd15; op0 = 2'b10;
    a1 = 4'd3;  b1 = 4'd5;  op1 = 2'b01;
    req = 2'b11;
    wait_done(0, "ct_done0", cyc);
    check("ct_no_done1", 32'(done[1]), 0);
    check("ct_result0", 32'(result), 225);
    req[0] = 1'b0;
    wait_done(1, "ct_done1", cyc);
    check("ct_order", 32'(cyc), SETTLE + 3);
    check("ct_grant1", 32'(grant), 32'h2);
    check("ct_result1", 32'(result), 14);
    req = 2'b00;
    @(negedge clk);

    // Invalid opcode; operand change while busy is ignored
    req = 2'b10; a1 = 4'd7; b1 = 4'd2; op1 = 2'b11;
    @(negedge clk);
    check("inv_alu_a", 32'(alu_a), 7);
    a1 = 4'd4;
    @(negedge clk);
    check("inv_latched", 32'(alu_a), 7);
    wait_done(1, "inv_done", cyc);
    check("inv_err", 32'(err), 1);
    check("inv_result", 32'(result), 0);
    req = 2'b00;
    @(negedge clk);
    check("inv_err_pulse", 32'(err), 0);

    // Reset mid-operation, then re-present
    @(negedge clk);
    req = 2'b01; a0 = 4'd2; b0 = 4'd3; op0 = 2'b10;
    @(negedge clk);
    @(negedge clk);
    check("mid_in_wait", 32'(alu_start), 1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 0);
    check("mid_grant", 32'(grant), 0);
    check("mid_done", 32'(done), 0);
    check("mid_result", 32'(result), 0);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_quiet", 32'({done, busy}), 0);
    req = 2'b01;
    wait_done(0, "mid_redo_done", cyc);
    check("mid_redo_result", 32'(result), 6);
    req = 2'b00;

    // Fairness: both held for 6 operations
    do_reset();
    a0 = 4'd1; b0 = 4'd1; op0 = 2'b00;
    a1 = 4'd6; b1 = 4'd7; op1 = 2'b00;
    req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (grant == 2'b00 && gap < 40);
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("fair_grant%0d", k), 32'(grant), 32'(exp_g));
      if (k > 0) check($sformatf("fair_gap%0d", k), 32'(gap), 2);
      wait_done((k % 2 == 0) ? 0 : 1, $sformatf("fair_done%0d", k), cyc);
      check($sformatf("fair_lat%0d", k), 32'(cyc), SETTLE + 1);
      check($sformatf("fair_res%0d", k), 32'(result), (k % 2 == 0) ? 2 : 13);
    end
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("fair_end_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
